doppler_ensemble_buffer: RTL and testbench
==========================================

# doppler_ensemble_buffer

Parametrised slow-time corner-turn buffer for the pulsed-Doppler receive path. It collects one sample per range gate per PRF for ENSEMBLE consecutive PRFs into a ping-pong RAM. It then streams the completed ensemble out gate-major, all PRFs of gate 0 first, to the spectral stage through a readNext handshake. It replaces the single-register, fixed four-PRF buffer. It adds channel width, depth and ensemble parameters, double buffering, overflow detection and a synchronous strobe interface.

## Interface
- WIDTH, 16, bits per channel sample
- CHANNELS, 2, channels packed per word (e.g. I/Q); word width = WIDTH*CHANNELS
- GATES, 64, range gates per PRF (>=2)
- ENSEMBLE, 4, PRFs per ensemble (>=2)

- clk  in  1  system clock, all logic on rising edge
- resetN  in  1  asynchronous, active-low reset
- dataIn  in  WIDTH*CHANNELS  sample word, qualified by sampleValid
- sampleValid  in  1  one-cycle strobe, write dataIn at current gate
- prfStart  in  1  one-cycle strobe, start of a PRF period
- readNext  in  1  consumer accepts dataOut this cycle
- clearErr  in  1  clears sticky error flags
- dataOut  out  WIDTH*CHANNELS  output word, reset 0
- dataValid  out  1  dataOut holds a valid word, reset 0
- lastOut  out  1  dataOut is the final word of the ensemble, reset 0
- ensembleReady  out  1  a completed ensemble is held in the read bank, reset 0
- gateOverrun  out  1  sticky, more than GATES samples in one PRF, reset 0
- overflow  out  1  sticky, an ensemble was discarded, reset 0

## Operation
- Write side states: IDLE (before first prfStart, sampleValid ignored) and FILL (prf index p, gate index g).
- prfStart in IDLE: p=0, g=0, enter FILL.
- prfStart in FILL with p<ENSEMBLE-1: p++, g=0.
- prfStart in FILL with p==ENSEMBLE-1 completes the ensemble:
  - Read bank free: swap banks, mark read bank full, p=0, g=0.
  - Read bank busy: discard the write bank contents, set overflow, p=0, g=0, no swap.
- sampleValid in FILL with g<GATES: write RAM[bank][p*GATES+g], g++.
- sampleValid in FILL with g==GATES: drop the sample, set gateOverrun.
- Simultaneous prfStart and sampleValid: prfStart is applied first, so the sample lands at gate 0 of the new PRF, or of the new ensemble.
- Short PRF (fewer than GATES samples): unwritten locations keep stale contents. No error is flagged.
- Read side output order: for g in 0..GATES-1, for p in 0..ENSEMBLE-1, word p*GATES+g.
- Word k is consumed when dataValid && readNext. After the last word (lastOut) is consumed, the read bank is freed and ensembleReady and dataValid fall.
- readNext while dataValid is low is ignored.
- clearErr clears both sticky flags. A same-cycle set event wins over clearErr.
- An address counter only ever runs in multiples of GATES*ENSEMBLE. No wrap occurs inside an ensemble.

## Timing
- prfStart completing an ensemble sampled at edge k:
  - ensembleReady high after edge k.
  - First word on dataOut with dataValid after edge k+1.
- Sustained throughput is 1 word/cycle. The RAM read address is selected combinationally from readNext, as the next address when consuming, else the current one. The next word appears after the edge at which readNext is sampled.
- dataOut is held stable while dataValid && !readNext.
- Last word consumed at edge m: dataValid, lastOut and ensembleReady low after edge m. The bank is free for a swap at a prfStart sampled at edge m+1 or later. A completion at edge m itself counts as busy and takes the overflow path.
- resetN low asserts immediately:
  - all outputs 0
  - state IDLE, bank pointer 0, read bank free
  - RAM contents not cleared
- Reset mid-readout abandons the ensemble.

## Structure
- Package doppler_buf_pkg holds:
  - clog2-based derived constants: GATE_W, PRF_W, ADDR_W = clog2(GATES*ENSEMBLE)+1 (the bank bit)
  - the write-state enum (IDLE, FILL)
- Sub-module sdp_ram is a simple dual-port RAM with 2*GATES*ENSEMBLE words. It has one write port and one registered read port, with 1-cycle latency and no reset.
- Top level holds the write FSM, the read address generator (gate/prf counters) and the bank/full flags.

## Test plan
Parameters for all scenarios: WIDTH=16, CHANNELS=1, GATES=4, ENSEMBLE=2.
- Basic: prfStart, samples 0x10..0x13, prfStart, 0x20..0x23, prfStart, readNext held high -> ensembleReady, then dataOut sequence 0x10,0x20,0x11,0x21,0x12,0x22,0x13,0x23 on consecutive cycles, lastOut only on 0x23.
- Gate overrun: 6 samples in one PRF -> samples 5 and 6 dropped, gateOverrun=1, readout identical to Basic. clearErr -> gateOverrun=0.
- Overflow: fill two ensembles (second uses 0x30..0x33/0x40..0x43) with readNext=0 -> overflow=1, readout returns first ensemble only. A third ensemble after draining is read out correctly.
- Back-pressure: readNext alternating 1/0 -> same sequence as Basic, dataOut stable during stalls, no duplicates or losses.
- Simultaneous: prfStart and sampleValid(0x55) in the same cycle -> 0x55 stored at gate 0, g=1 afterwards.
- Reset mid-readout: resetN low after 3 words -> all outputs 0 immediately. The next three-prfStart sequence reads out cleanly from prf 0, bank 0.

Source files
------------

// File: rtl/doppler_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : doppler_buf_pkg
// Purpose  : Shared types and width helpers for the Doppler ensemble buffer
// Revision : 1.0  initial release
// ============================================================================
package doppler_buf_pkg;

    // Write-side fill state
    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_FILL = 1'b1
    } wr_state_t;

    // Gate counter must be able to hold GATES itself (the "PRF full" value)
    function automatic int gate_w(input int gates);
        return $clog2(gates + 1);
    endfunction

    // PRF counter covers 0..ENSEMBLE-1
    function automatic int prf_w(input int ens);
        return (ens > 2) ? $clog2(ens) : 1;
    endfunction

    // Word address across both banks: one ensemble plus the bank bit
    function automatic int addr_w(input int gates, input int ens);
        return $clog2(gates * ens) + 1;
    endfunction

    // Widths for the default configuration
    localparam int DEF_GATES    = 64;
    localparam int DEF_ENSEMBLE = 4;
    localparam int GATE_W       = gate_w(DEF_GATES);
    localparam int PRF_W        = prf_w(DEF_ENSEMBLE);
    localparam int ADDR_W       = addr_w(DEF_GATES, DEF_ENSEMBLE);

endpackage
`default_nettype wire

// File: rtl/sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram
// Purpose  : Simple dual-port RAM, one write port, registered read port
//            (1-cycle latency), contents not reset
// Revision : 1.0  initial release
// ============================================================================
module sdp_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_q;

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/doppler_ensemble_buffer.sv
`default_nettype none
// ============================================================================
// Module   : doppler_ensemble_buffer
// Purpose  : Slow-time corner-turn buffer. Collects ENSEMBLE PRFs of GATES
//            samples into a ping-pong RAM and streams each completed
//            ensemble out gate-major under a readNext handshake.
// Revision : 1.0  initial release
// ============================================================================
module doppler_ensemble_buffer
    import doppler_buf_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int GATES    = 64,
    parameter int ENSEMBLE = 4
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [WIDTH*CHANNELS-1:0] dataIn,
    input  logic                      sampleValid,
    input  logic                      prfStart,
    input  logic                      readNext,
    input  logic                      clearErr,
    output logic [WIDTH*CHANNELS-1:0] dataOut,
    output logic                      dataValid,
    output logic                      lastOut,
    output logic                      ensembleReady,
    output logic                      gateOverrun,
    output logic                      overflow
);

    localparam int c_DW    = WIDTH * CHANNELS;
    localparam int c_GW    = gate_w(GATES);
    localparam int c_PW    = prf_w(ENSEMBLE);
    localparam int c_AW    = addr_w(GATES, ENSEMBLE);
    localparam int c_DEPTH = 2 * GATES * ENSEMBLE;

    localparam logic [c_AW-1:0] c_GATES_A  = c_AW'(GATES);
    localparam logic [c_AW-1:0] c_BANK_OFS = c_AW'(GATES * ENSEMBLE);
    localparam logic [c_GW-1:0] c_GATES_G  = c_GW'(GATES);
    localparam logic [c_GW-1:0] c_LAST_G   = c_GW'(GATES - 1);
    localparam logic [c_PW-1:0] c_LAST_P   = c_PW'(ENSEMBLE - 1);

    // Write side state
    wr_state_t       r_state;
    logic [c_PW-1:0] r_p;
    logic [c_GW-1:0] r_g;
    logic            r_bank;     // bank being written; read bank is ~r_bank

    // Read side state
    logic            r_full;
    logic            r_valid;
    logic [c_GW-1:0] r_rg;
    logic [c_PW-1:0] r_rp;
    logic            r_gover;
    logic            r_ovf;

    logic [c_PW-1:0] w_p_eff;
    logic [c_GW-1:0] w_g_eff;
    logic            w_fill_eff;
    logic            w_complete;
    logic            w_swap;
    logic            w_discard;
    logic            w_bank_eff;
    logic            w_we;
    logic            w_drop;
    logic [c_AW-1:0] w_waddr;

    logic            w_consume;
    logic            w_rlast;
    logic [c_GW-1:0] w_rg_n;
    logic [c_PW-1:0] w_rp_n;
    logic [c_AW-1:0] w_raddr;
    logic [c_DW-1:0] w_rdata;

    // prfStart is resolved before sampleValid so a coincident sample lands
    // at gate 0 of the new PRF (or of the new ensemble / new bank)
    always_comb begin
        w_p_eff    = r_p;
        w_g_eff    = r_g;
        w_fill_eff = (r_state == WR_FILL);
        w_complete = 1'b0;
        if (prfStart) begin
            w_fill_eff = 1'b1;
            w_g_eff    = '0;
            if (r_state == WR_IDLE) begin
                w_p_eff = '0;
            end else if (r_p != c_LAST_P) begin
                w_p_eff = r_p + c_PW'(1);
            end else begin
                w_p_eff    = '0;
                w_complete = 1'b1;
            end
        end
        w_swap     = w_complete && !r_full;
        w_discard  = w_complete && r_full;
        w_bank_eff = r_bank ^ w_swap;
        w_we       = sampleValid && w_fill_eff && (w_g_eff != c_GATES_G);
        w_drop     = sampleValid && w_fill_eff && (w_g_eff == c_GATES_G);
        w_waddr    = (w_bank_eff ? c_BANK_OFS : '0)
                   + c_AW'(w_p_eff) * c_GATES_A + c_AW'(w_g_eff);
    end

    // Read address: next word when the current one is being consumed, else
    // re-read the current one so dataOut holds during a stall
    always_comb begin
        w_consume = r_valid && readNext;
        w_rlast   = (r_rg == c_LAST_G) && (r_rp == c_LAST_P);
        w_rg_n    = r_rg;
        w_rp_n    = r_rp;
        if (w_consume) begin
            if (r_rp == c_LAST_P) begin
                w_rp_n = '0;
                w_rg_n = w_rlast ? '0 : r_rg + c_GW'(1);
            end else begin
                w_rp_n = r_rp + c_PW'(1);
            end
        end
        w_raddr = (r_bank ? '0 : c_BANK_OFS)
                + c_AW'(w_rp_n) * c_GATES_A + c_AW'(w_rg_n);
    end

    // Write FSM: PRF/gate counters and bank pointer
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= WR_IDLE;
            r_p     <= '0;
            r_g     <= '0;
            r_bank  <= 1'b0;
        end else begin
            if (prfStart) begin
                r_state <= WR_FILL;
            end
            r_p    <= w_p_eff;
            r_g    <= w_we ? w_g_eff + c_GW'(1) : w_g_eff;
            r_bank <= w_bank_eff;
        end
    end

    // Read sequencing, bank-full flag and sticky error flags
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_full  <= 1'b0;
            r_valid <= 1'b0;
            r_rg    <= '0;
            r_rp    <= '0;
            r_gover <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_consume && w_rlast) begin
                r_full <= 1'b0;
            end else if (w_swap) begin
                r_full <= 1'b1;
            end
            r_valid <= r_full && !(w_consume && w_rlast);
            r_rg    <= w_rg_n;
            r_rp    <= w_rp_n;
            r_gover <= w_drop    ? 1'b1 : (clearErr ? 1'b0 : r_gover);
            r_ovf   <= w_discard ? 1'b1 : (clearErr ? 1'b0 : r_ovf);
        end
    end

    sdp_ram #(
        .WIDTH  (c_DW),
        .DEPTH  (c_DEPTH),
        .ADDR_W (c_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (dataIn),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // RAM output is unreset, so gate it to keep dataOut at 0 when idle
    assign dataOut       = r_valid ? w_rdata : '0;
    assign dataValid     = r_valid;
    assign lastOut       = r_valid && w_rlast;
    assign ensembleReady = r_full;
    assign gateOverrun   = r_gover;
    assign overflow      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_doppler_ensemble_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_doppler_ensemble_buffer
// Purpose  : Self-checking bench for doppler_ensemble_buffer with an
//            ensemble-level reference model
// Revision : 1.0  initial release
// ============================================================================
module tb_doppler_ensemble_buffer;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 1;
    localparam int GATES    = 4;
    localparam int ENSEMBLE = 2;
    localparam int N        = GATES * ENSEMBLE;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic [15:0] dataIn = '0;
    logic        sampleValid = 1'b0;
    logic        prfStart = 1'b0;
    logic        readNext = 1'b0;
    logic        clearErr = 1'b0;
    logic [15:0] dataOut;
    logic        dataValid;
    logic        lastOut;
    logic        ensembleReady;
    logic        gateOverrun;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    // Reference model: two banks of [prf][gate] samples plus readout list
    logic [15:0] mmem [2][ENSEMBLE][GATES];
    logic [15:0] mlist [N];
    bit          mfill, mready, mvalid, movf, mgov;
    int          mp, mg, mbank, mk;
    logic [15:0] got_q [$];
    logic [15:0] exp_basic [N];

    doppler_ensemble_buffer #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .GATES    (GATES),
        .ENSEMBLE (ENSEMBLE)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .dataIn        (dataIn),
        .sampleValid   (sampleValid),
        .prfStart      (prfStart),
        .readNext      (readNext),
        .clearErr      (clearErr),
        .dataOut       (dataOut),
        .dataValid     (dataValid),
        .lastOut       (lastOut),
        .ensembleReady (ensembleReady),
        .gateOverrun   (gateOverrun),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string where);
        logic [15:0] e_do;
        e_do = mvalid ? mlist[mk] : 16'h0;
        chk({where, ".dataOut"},       {16'h0, dataOut},       {16'h0, e_do});
        chk({where, ".dataValid"},     {31'h0, dataValid},     {31'h0, mvalid});
        chk({where, ".lastOut"},       {31'h0, lastOut},       {31'h0, (mvalid && mk == N-1)});
        chk({where, ".ensembleReady"}, {31'h0, ensembleReady}, {31'h0, mready});
        chk({where, ".gateOverrun"},   {31'h0, gateOverrun},   {31'h0, mgov});
        chk({where, ".overflow"},      {31'h0, overflow},      {31'h0, movf});
    endtask

    task automatic model_reset();
        mfill = 0; mready = 0; mvalid = 0; movf = 0; mgov = 0;
        mp = 0; mg = 0; mbank = 0; mk = 0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once
    task automatic do_reset();
        #2 resetN = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge
    task automatic cyc(input bit prf, input bit sv, input logic [15:0] d,
                       input bit rn, input bit clr);
        bit old_ready, consume, ovf_set, gov_set;
        prfStart = prf; sampleValid = sv; dataIn = d; readNext = rn; clearErr = clr;
        if (dataValid && rn) got_q.push_back(dataOut);

        old_ready = mready;
        consume   = mvalid && rn;
        if (consume && mk == N-1) begin
            mready = 0; mvalid = 0; mk = 0;
        end else begin
            if (consume) mk++;
            mvalid = old_ready;
        end

        ovf_set = 0; gov_set = 0;
        if (prf) begin
            if (!mfill) begin
                mfill = 1; mp = 0;
            end else if (mp < ENSEMBLE-1) begin
                mp++;
            end else begin
                mp = 0;
                if (!old_ready) begin
                    for (int g = 0; g < GATES; g++)
                        for (int p = 0; p < ENSEMBLE; p++)
                            mlist[g*ENSEMBLE + p] = mmem[mbank][p][g];
                    mbank  = 1 - mbank;
                    mready = 1;
                end else begin
                    ovf_set = 1;
                end
            end
            mg = 0;
        end
        if (sv && mfill) begin
            if (mg < GATES) begin
                mmem[mbank][mp][mg] = d;
                mg++;
            end else begin
                gov_set = 1;
            end
        end
        movf = ovf_set ? 1'b1 : (clr ? 1'b0 : movf);
        mgov = gov_set ? 1'b1 : (clr ? 1'b0 : mgov);

        @(posedge clk);
        #1;
        check_outputs("cyc");
        prfStart = 0; sampleValid = 0; dataIn = '0; readNext = 0; clearErr = 0;
    endtask

    // From the start of prf 0: GATES samples, prfStart, GATES samples, prfStart
    task automatic ens(input logic [15:0] b0, input logic [15:0] b1, input bit rnd);
        for (int i = 0; i < GATES; i++)
            cyc(0, 1, rnd ? 16'($urandom) : b0 + 16'(i), 0, 0);
        cyc(1, 0, 16'h0, 0, 0);
        for (int i = 0; i < GATES; i++)
            cyc(0, 1, rnd ? 16'($urandom) : b1 + 16'(i), 0, 0);
        cyc(1, 0, 16'h0, 0, 0);
    endtask

    // mode 0: readNext high, 1: alternating, 2: random
    task automatic drain(input int mode);
        int  i;
        bit  rn;
        i = 0;
        got_q.delete();
        while (mready && i < 60) begin
            rn = (mode == 0) ? 1'b1 : (mode == 1) ? ~i[0] : 1'($urandom_range(0, 1));
            cyc(0, 0, 16'h0, rn, 0);
            i++;
        end
        chk("drain_done", {31'h0, ensembleReady}, 32'h0);
    endtask

    task automatic check_basic_seq(input string tag);
        chk({tag, ".count"}, got_q.size(), N);
        for (int i = 0; i < N && i < got_q.size(); i++)
            chk($sformatf("%s.word%0d", tag, i), {16'h0, got_q[i]}, {16'h0, exp_basic[i]});
    endtask

    initial begin
        exp_basic = '{16'h10, 16'h20, 16'h11, 16'h21, 16'h12, 16'h22, 16'h13, 16'h23};
        for (int b = 0; b < 2; b++)
            for (int p = 0; p < ENSEMBLE; p++)
                for (int g = 0; g < GATES; g++)
                    mmem[b][p][g] = '0;

        do_reset();

        // Samples before the first prfStart are ignored
        cyc(0, 1, 16'hDEAD, 0, 0);

        // Basic
        cyc(1, 0, 16'h0, 0, 0);
        ens(16'h10, 16'h20, 0);
        drain(0);
        check_basic_seq("basic");

        // Gate overrun: 6 samples in one PRF
        for (int i = 0; i < 6; i++)
            cyc(0, 1, (i < GATES) ? 16'h10 + 16'(i) : 16'($urandom), 0, 0);
        cyc(1, 0, 16'h0, 0, 0);
        for (int i = 0; i < GATES; i++)
            cyc(0, 1, 16'h20 + 16'(i), 0, 0);
        cyc(1, 0, 16'h0, 0, 0);
        chk("overrun.flag", {31'h0, gateOverrun}, 32'h1);
        drain(0);
        check_basic_seq("overrun");
        cyc(0, 0, 16'h0, 0, 1);
        chk("overrun.cleared", {31'h0, gateOverrun}, 32'h0);

        // Overflow: second ensemble completes while the first is unread
        ens(16'h10, 16'h20, 0);
        ens(16'h30, 16'h40, 0);
        chk("overflow.flag", {31'h0, overflow}, 32'h1);
        drain(0);
        check_basic_seq("overflow");
        ens(16'h0, 16'h0, 1);
        drain(2);
        cyc(0, 0, 16'h0, 0, 1);

        // Back-pressure, alternating then random
        ens(16'h10, 16'h20, 0);
        drain(1);
        check_basic_seq("backpressure");
        ens(16'h0, 16'h0, 1);
        drain(2);

        // Simultaneous prfStart + sampleValid
        for (int i = 0; i < GATES; i++)
            cyc(0, 1, 16'h70 + 16'(i), 0, 0);
        cyc(1, 1, 16'h55, 0, 0);
        for (int i = 1; i < GATES; i++)
            cyc(0, 1, 16'h80 + 16'(i), 0, 0);
        cyc(1, 1, 16'h66, 0, 0);
        drain(0);
        chk("simul.count", got_q.size(), N);
        if (got_q.size() > 2) begin
            chk("simul.gate0_word", {16'h0, got_q[1]}, 32'h55);
            chk("simul.gate1_word", {16'h0, got_q[3]}, 32'h81);
        end
        for (int i = 1; i < GATES; i++)
            cyc(0, 1, 16'h90 + 16'(i), 0, 0);
        cyc(1, 0, 16'h0, 0, 0);
        for (int i = 0; i < GATES; i++)
            cyc(0, 1, 16'hA0 + 16'(i), 0, 0);
        cyc(1, 0, 16'h0, 0, 0);
        drain(0);
        if (got_q.size() > 0)
            chk("simul.new_ens_word0", {16'h0, got_q[0]}, 32'h66);

        // Reset mid-readout
        ens(16'h0, 16'h0, 1);
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 16'h0, 1, 0);
        do_reset();
        cyc(1, 0, 16'h0, 0, 0);
        ens(16'h0, 16'h0, 1);
        drain(0);

        // Random traffic
        for (int i = 0; i < 300; i++)
            cyc(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
                1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
